// File: rtl/division_sequencer_pkg.sv
// Shared types and constants for the signed division sequencer:
// FSM state enum, result status codes, operand width, timeout default.
package division_sequencer_pkg;

    localparam int OP_W            = 16;
    localparam int TIMEOUT_DEFAULT = 64;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_FIX,
        S_HOLD
    } state_e;

    typedef enum logic [1:0] {
        STAT_OK      = 2'b00,
        STAT_DIV0    = 2'b01,
        STAT_OVF     = 2'b10,
        STAT_TIMEOUT = 2'b11
    } status_e;

endpackage

// File: rtl/division_sequencer_sign_magnitude_unit.sv
// Combinational conditional negate: res = neg ? -val : val.
// Ports: val (operand), neg (negate enable), res (result).
// Used as abs() with neg = val[MSB]; -32768 maps to 16'h8000.
module sign_magnitude_unit
    import division_sequencer_pkg::*;
(
    input  logic [OP_W-1:0] val,
    input  logic            neg,
    output logic [OP_W-1:0] res
);

    assign res = neg ? (~val + OP_W'(1)) : val;

endmodule

// File: rtl/division_sequencer.sv
// Signed division front-end around an unsigned multi-cycle divider core.
// Ports: clk/rst (sync, active-high); in_* request handshake with signed
// operands; div_* launch/result interface to the unsigned core;
// out_* result handshake with signed quotient/remainder and 2-bit status.
module division_sequencer
    import division_sequencer_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_dividend,
    input  logic [15:0] in_divisor,
    output logic        div_start,
    output logic [15:0] div_dividend,
    output logic [15:0] div_divisor,
    input  logic [15:0] div_quotient,
    input  logic [16:0] div_remainder,
    input  logic        div_done,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_quotient,
    output logic [15:0] out_remainder,
    output logic [1:0]  out_status
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    state_e            state_q, state_d;
    status_e           status_q, status_d;
    logic              dvd_neg_q, dvd_neg_d;
    logic              quo_neg_q, quo_neg_d;
    logic              ovf_q, ovf_d;
    logic [OP_W-1:0]   dvd_mag_q, dvd_mag_d;
    logic [OP_W-1:0]   dvs_mag_q, dvs_mag_d;
    logic [OP_W-1:0]   quo_q, quo_d;
    logic [OP_W-1:0]   rem_q, rem_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [OP_W-1:0]   abs_dvd, abs_dvs;
    logic [OP_W-1:0]   fix_quo, fix_rem;

    // Core remainder MSB carries no information for 16-bit operands.
    logic unused_rem_msb;
    assign unused_rem_msb = div_remainder[16];

    sign_magnitude_unit u_abs_dvd (
        .val (in_dividend),
        .neg (in_dividend[OP_W-1]),
        .res (abs_dvd)
    );

    sign_magnitude_unit u_abs_dvs (
        .val (in_divisor),
        .neg (in_divisor[OP_W-1]),
        .res (abs_dvs)
    );

    sign_magnitude_unit u_fix_quo (
        .val (quo_q),
        .neg (quo_neg_q),
        .res (fix_quo)
    );

    sign_magnitude_unit u_fix_rem (
        .val (rem_q),
        .neg (dvd_neg_q),
        .res (fix_rem)
    );

    always_comb begin
        state_d   = state_q;
        status_d  = status_q;
        dvd_neg_d = dvd_neg_q;
        quo_neg_d = quo_neg_q;
        ovf_d     = ovf_q;
        dvd_mag_d = dvd_mag_q;
        dvs_mag_d = dvs_mag_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    dvd_neg_d = in_dividend[OP_W-1];
                    quo_neg_d = in_dividend[OP_W-1] ^ in_divisor[OP_W-1];
                    ovf_d     = (in_dividend == 16'h8000) &&
                                (in_divisor == 16'hFFFF);
                    dvd_mag_d = abs_dvd;
                    dvs_mag_d = abs_dvs;
                    if (in_divisor == '0) begin
                        // Divide-by-zero resolves locally; core untouched.
                        quo_d    = '1;
                        rem_d    = in_dividend;
                        status_d = STAT_DIV0;
                        state_d  = S_HOLD;
                    end else begin
                        state_d  = S_LAUNCH;
                    end
                end
            end
            S_LAUNCH: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (div_done) begin
                    quo_d   = div_quotient;
                    rem_d   = div_remainder[OP_W-1:0];
                    state_d = S_FIX;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    quo_d    = '0;
                    rem_d    = '0;
                    status_d = STAT_TIMEOUT;
                    state_d  = S_HOLD;
                end
            end
            S_FIX: begin
                if (ovf_q) begin
                    quo_d    = 16'h8000;
                    rem_d    = '0;
                    status_d = STAT_OVF;
                end else begin
                    quo_d    = fix_quo;
                    rem_d    = fix_rem;
                    status_d = STAT_OK;
                end
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            status_q  <= STAT_OK;
            dvd_neg_q <= 1'b0;
            quo_neg_q <= 1'b0;
            ovf_q     <= 1'b0;
            dvd_mag_q <= '0;
            dvs_mag_q <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            status_q  <= status_d;
            dvd_neg_q <= dvd_neg_d;
            quo_neg_q <= quo_neg_d;
            ovf_q     <= ovf_d;
            dvd_mag_q <= dvd_mag_d;
            dvs_mag_q <= dvs_mag_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
        end
    end

    assign in_ready      = (state_q == S_IDLE);
    assign div_start     = (state_q == S_LAUNCH);
    assign out_valid     = (state_q == S_HOLD);
    assign div_dividend  = dvd_mag_q;
    assign div_divisor   = dvs_mag_q;
    assign out_quotient  = quo_q;
    assign out_remainder = rem_q;
    assign out_status    = status_q;

endmodule

// File: tb/tb_division_sequencer.sv
// Randomized self-checking bench for division_sequencer with an
// unsigned divider-core stub of programmable latency.
module tb_division_sequencer;

    localparam int TO = 24;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_dividend = '0;
    logic [15:0] in_divisor = '0;
    logic        div_start;
    logic [15:0] div_dividend;
    logic [15:0] div_divisor;
    logic [15:0] div_quotient = '0;
    logic [16:0] div_remainder = '0;
    logic        div_done;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_quotient;
    logic [15:0] out_remainder;
    logic [1:0]  out_status;

    int checks = 0;
    int errors = 0;

    // core stub state
    int          core_lat = 1;
    bit          core_en = 1'b1;
    int          core_left = 0;
    int          starts = 0;
    logic [15:0] core_a, core_b;
    logic        core_done = 1'b0;
    logic        stray_done = 1'b0;

    assign div_done = core_done | stray_done;

    always #5 clk = ~clk;

    division_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_dividend   (in_dividend),
        .in_divisor    (in_divisor),
        .div_start     (div_start),
        .div_dividend  (div_dividend),
        .div_divisor   (div_divisor),
        .div_quotient  (div_quotient),
        .div_remainder (div_remainder),
        .div_done      (div_done),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_quotient  (out_quotient),
        .out_remainder (out_remainder),
        .out_status    (out_status)
    );

    // Unsigned core: done asserted core_lat cycles after the start cycle.
    always @(negedge clk) begin
        core_done = 1'b0;
        if (core_left > 0) begin
            core_left = core_left - 1;
            if (core_left == 0) begin
                core_done = 1'b1;
                div_quotient = core_a / core_b;
                div_remainder = {1'($urandom), core_a % core_b};
            end
        end
        if (div_start) begin
            starts = starts + 1;
            if (core_en) begin
                core_a = div_dividend;
                core_b = div_divisor;
                core_left = core_lat;
            end
        end
    end

    function automatic void model(input int a, input int b,
                                  output logic [15:0] q,
                                  output logic [15:0] r,
                                  output logic [1:0] s);
        int qi;
        int ri;
        if (b == 0) begin
            q = 16'hFFFF; r = a[15:0]; s = 2'b01;
        end else if (a == -32768 && b == -1) begin
            q = 16'h8000; r = 16'h0000; s = 2'b10;
        end else begin
            qi = a / b;
            ri = a % b;
            q = qi[15:0]; r = ri[15:0]; s = 2'b00;
        end
    endfunction

    task automatic run_txn(input int a, input int b, input int lat,
                           input bit hang, input int stall,
                           input string tag);
        logic [15:0] eq, er;
        logic [1:0]  es;
        int cyc, exp_lat, s0;
        model(a, b, eq, er, es);
        if (hang && b != 0) begin
            eq = '0; er = '0; es = 2'b11;
        end
        exp_lat = (b == 0) ? 1 : (hang ? TO + 2 : lat + 3);
        core_lat = lat;
        core_en = !hang;
        cyc = 0;
        while (!in_ready && cyc < 20) begin
            @(negedge clk); cyc++;
        end
        s0 = starts;
        in_valid = 1'b1;
        in_dividend = a[15:0];
        in_divisor = b[15:0];
        @(negedge clk);
        in_valid = 1'b0;
        in_dividend = 16'($urandom);
        in_divisor = 16'($urandom);
        cyc = 1;
        while (!out_valid && cyc < TO + 60) begin
            @(negedge clk); cyc++;
        end
        checks++;
        if (!out_valid || cyc != exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d (valid=%0b) expected %0d",
                     tag, cyc, out_valid, exp_lat);
        end
        checks++;
        if (out_quotient !== eq || out_remainder !== er ||
            out_status !== es) begin
            errors++;
            $display("FAIL %s result %0d/%0d: got q=%h r=%h s=%b expected q=%h r=%h s=%b",
                     tag, a, b, out_quotient, out_remainder, out_status,
                     eq, er, es);
        end
        checks++;
        if ((starts - s0) != ((b == 0) ? 0 : 1) || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s starts/in_ready: got %0d/%0b expected %0d/0",
                     tag, starts - s0, in_ready, (b == 0) ? 0 : 1);
        end
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1;
            in_dividend = 16'($urandom);
            in_divisor = 16'($urandom);
            stray_done = i[0];
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
                out_quotient !== eq || out_remainder !== er ||
                out_status !== es) begin
                errors++;
                $display("FAIL %s stall%0d: got v=%b rdy=%b q=%h r=%h s=%b expected v=1 rdy=0 q=%h r=%h s=%b",
                         tag, i, out_valid, in_ready, out_quotient,
                         out_remainder, out_status, eq, er, es);
            end
        end
        in_valid = 1'b0;
        stray_done = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s release: got v=%b rdy=%b expected v=0 rdy=1",
                     tag, out_valid, in_ready);
        end
        core_en = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || div_start !== 1'b0 || out_valid !== 1'b0 ||
            out_status !== 2'b00 || out_quotient !== 16'h0 ||
            out_remainder !== 16'h0) begin
            errors++;
            $display("FAIL reset: got rdy=%b st=%b v=%b s=%b q=%h r=%h expected 1 0 0 00 0000 0000",
                     in_ready, div_start, out_valid, out_status,
                     out_quotient, out_remainder);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        run_txn(100, 7, 2, 0, 0, "pos_pos");
        run_txn(-100, 7, 1, 0, 0, "neg_pos");
        run_txn(100, -7, 4, 0, 0, "pos_neg");
        run_txn(-100, -7, 3, 0, 0, "neg_neg");
        run_txn(-32768, -1, 2, 0, 0, "overflow");
        run_txn(-32768, 1, 2, 0, 0, "min_by_one");
        run_txn(5, 0, 2, 0, 0, "div_zero");
        run_txn(-32768, 0, 2, 0, 0, "min_div_zero");
        run_txn(3, 32767, 1, 0, 0, "small_big");
    endtask

    task automatic test_random();
        logic [15:0] ra, rb;
        int a, b, k;
        for (int n = 0; n < 40; n++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            k = $urandom_range(0, 9);
            if (k == 0) rb = 16'h0000;
            if (k == 1) begin ra = 16'h8000; rb = 16'hFFFF; end
            if (k == 2) ra = 16'h8000;
            if (k == 3) rb = 16'(1 + $urandom_range(0, 15));
            a = int'($signed(ra));
            b = int'($signed(rb));
            run_txn(a, b, $urandom_range(1, 8), 0, 0, "random");
        end
    endtask

    task automatic test_timeout();
        run_txn(1000, 3, 1, 1, 0, "timeout");
        run_txn(1000, 3, 5, 0, 0, "after_timeout");
    endtask

    task automatic test_hold_stall();
        run_txn(-100, 7, 2, 0, 10, "stall");
    endtask

    task automatic test_reset_mid_wait();
        int s0;
        bit seen;
        core_lat = 30;
        core_en = 1'b1;
        in_valid = 1'b1;
        in_dividend = 16'd1234;
        in_divisor = 16'd5;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || div_start !== 1'b0 ||
            out_status !== 2'b00 || out_quotient !== 16'h0 ||
            out_remainder !== 16'h0) begin
            errors++;
            $display("FAIL reset_mid: got rdy=%b v=%b st=%b s=%b q=%h r=%h expected 1 0 0 00 0000 0000",
                     in_ready, out_valid, div_start, out_status,
                     out_quotient, out_remainder);
        end
        s0 = starts;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || in_ready !== 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen || starts != s0) begin
            errors++;
            $display("FAIL late_done: got disturbed=%0b starts=%0d expected 0 and %0d",
                     seen, starts, s0);
        end
        run_txn(-7, 2, 2, 0, 0, "after_reset");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_timeout();
        test_hold_stall();
        test_reset_mid_wait();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/division_sequencer.md
DIVISION_SEQUENCER -- requirements
Module: division_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64: maximum cycles to wait for div_done after div_start before aborting.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  request operands valid.
REQ-005 in_ready  output  1  sequencer accepts a request this cycle.
REQ-006 in_dividend  input  16  signed two's-complement dividend.
REQ-007 in_divisor  input  16  signed two's-complement divisor.
REQ-008 div_start  output  1  one-cycle launch pulse to the unsigned divider core.
REQ-009 div_dividend  output  16  unsigned dividend magnitude to the core.
REQ-010 div_divisor  output  16  unsigned divisor magnitude to the core.
REQ-011 div_quotient  input  16  unsigned quotient from the core.
REQ-012 div_remainder  input  17  remainder from the core; bits [15:0] used, bit 16 ignored.
REQ-013 div_done  input  1  core completion, sampled only in WAIT.
REQ-014 out_valid  output  1  result valid.
REQ-015 out_ready  input  1  consumer accepts result.
REQ-016 out_quotient  output  16  signed quotient.
REQ-017 out_remainder  output  16  signed remainder.
REQ-018 out_status  output  2  00 ok, 01 divide-by-zero, 10 overflow, 11 timeout.

Function
REQ-019 FSM states: IDLE, LAUNCH, WAIT, FIX, HOLD.
REQ-020 in_ready SHALL be 1 only in IDLE; a request is accepted on in_valid & in_ready.
REQ-021 On accept, operand signs and magnitudes are registered; divisor==0 -> HOLD next cycle with quotient 16'hFFFF, remainder = in_dividend, status 01, core never started.
REQ-022 Otherwise accept -> LAUNCH; LAUNCH asserts div_start for exactly one cycle -> WAIT.
REQ-023 div_dividend/div_divisor SHALL hold the registered magnitudes from LAUNCH until leaving WAIT; magnitude of -32768 is 16'h8000.
REQ-024 WAIT: first cycle with div_done=1 captures quotient/remainder -> FIX; a wait counter cleared in LAUNCH increments per WAIT cycle.
REQ-025 Counter reaching TIMEOUT_CYCLES without div_done -> HOLD with status 11, quotient and remainder 0.
REQ-026 FIX (one cycle): quotient negated if operand signs differ; remainder negated if dividend negative; -> HOLD.
REQ-027 Overflow: dividend -32768, divisor -1 -> status 10, quotient 16'h8000, remainder 0.
REQ-028 Quotient truncates toward zero; remainder takes dividend sign; |remainder| < |divisor|.
REQ-029 HOLD asserts out_valid; outputs stable while out_valid & !out_ready; out_valid & out_ready -> IDLE.
REQ-030 Latency for nonzero divisor: accept to out_valid = core latency + 3 cycles.
REQ-031 div_done outside WAIT SHALL be ignored; in_valid outside IDLE SHALL be ignored.

Reset
REQ-032 rst SHALL force IDLE, in_ready 1 next cycle, div_start 0, out_valid 0, out_status 00, out_quotient 0, out_remainder 0, counter 0.
REQ-033 rst mid-operation SHALL abandon the request without a result; a late div_done after reset SHALL be ignored.

Structure
REQ-034 Shared package holds the state enum, status codes, operand width 16, and TIMEOUT_CYCLES default.
REQ-035 One sub-module, sign_magnitude_unit: combinational abs/conditional-negate, instantiated for input and output correction.

Verification
REQ-036 100 / 7 -> quotient 14, remainder 2, status 00.
REQ-037 -100 / 7 -> quotient -14, remainder -2; 100 / -7 -> quotient -14, remainder 2.
REQ-038 -32768 / -1 -> quotient 16'h8000, remainder 0, status 10; 5 / 0 -> quotient 16'hFFFF, remainder 5, status 01, div_start never pulses.
REQ-039 Core stub never asserts div_done -> status 11 exactly TIMEOUT_CYCLES cycles after entering WAIT; next request processes normally.
REQ-040 out_ready held low 10 cycles -> outputs stable, in_ready 0; rst asserted during WAIT -> IDLE, no out_valid.
